icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, read-only instruction cache sitting directly upstream of the instruction-fetch stage. It serves 32-bit instruction reads addressed by the fetch PC, raises a stall on miss, and refills whole 128-bit lines from main memory over a request/ready handshake. Its processor-side ports connect to the fetch stage's `ICACHE_*` signals. Its memory-side ports connect to the instruction memory or arbiter.

## Interface
- `LINE_NUM`, 8, number of cache lines; power of two, ≥2. Index width `IW = log2(LINE_NUM)`.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `proc_read` input 1: read request from fetch.
- `proc_write` input 1: write request. Ignored; the cache is read-only.
- `proc_addr` input 30: word address. Bits [1:0] are the word offset, [IW+1:2] the index, [29:IW+2] the tag.
- `proc_wdata` input 32: ignored.
- `proc_rdata` output 32: selected instruction word.
- `proc_stall` output 1: fetch must hold its PC.
- `mem_read` output 1: line-fill request (registered).
- `mem_write` output 1: tied 0.
- `mem_addr` output 28: line address `proc_addr[29:2]` (registered).
- `mem_wdata` output 128: tied 0.
- `mem_rdata` input 128: refill line; word k is `[32k+31:32k]`.
- `mem_ready` input 1: one-cycle pulse; `mem_rdata` is valid in the same cycle.

## Operation
Per-line storage:
- valid bit,
- tag of `30-2-IW` bits,
- 128-bit data.

Hit condition: `valid[idx]` set and stored tag equals `proc_addr` tag.

States:
- **S_IDLE**
  - `proc_read`=0 or hit: stay in S_IDLE.
  - `proc_read`=1 and miss: go to S_FETCH. Register `mem_read`←1 and `mem_addr`←`proc_addr[29:2]`.
- **S_FETCH**
  - Hold `mem_read`=1 and `mem_addr` constant.
  - On `mem_ready`=1: write `mem_rdata` to the line at the latched address's index, set the tag from the latched address, set valid. Clear `mem_read` and go to S_IDLE.

Output rules:
- `proc_stall` = (S_IDLE & `proc_read` & ~hit) | S_FETCH. It is combinational.
- `proc_rdata` = word `proc_addr[1:0]` of line `idx`, combinational. It is meaningful only when `proc_read` & ~`proc_stall`.

Boundary conditions:
- `proc_addr` changes during S_FETCH (branch redirect): the fill still completes to the latched address. The new address is looked up in S_IDLE afterwards.
- `mem_ready` seen in S_IDLE: ignored.
- `proc_write`=1: no stall, no memory traffic, no state change.
- Conflict miss: the fill overwrites the line unconditionally. No writeback.

Reset (async, `rst_n`=0):
- all valid bits 0,
- state S_IDLE,
- `mem_read`=0, `mem_addr`=0.

Tag and data contents are not reset. Reset mid-fill abandons the fill.

## Timing
- Hit: 0 cycles. Data is available in the same cycle as the request, with `proc_stall`=0.
- Miss: miss detected in cycle N, `proc_stall`=1 combinationally. `mem_read`=1 from cycle N+1. `mem_ready` is sampled in cycle M and the line is written at the end of M. Cycle M+1 is a hit with `proc_stall`=0.
- Minimum miss penalty: 2 cycles, when `mem_ready` arrives in cycle N+1.
- `mem_read` deasserts in cycle M+1.
- Back-to-back misses: the next request can issue no earlier than M+2.

## Configuration
- `ICACHE_PERF_EN` defined: adds output ports `hit_cnt` [31:0] and `miss_cnt` [31:0].
  - `hit_cnt` increments each cycle with S_IDLE & `proc_read` & hit.
  - `miss_cnt` increments on each S_IDLE→S_FETCH transition.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: no such ports and no counter logic.

## Structure
- Shared include/package holds:
  - state encodings `S_IDLE`/`S_FETCH`,
  - `LINE_W`=128, `WORD_W`=32,
  - `NOP`=32'h00000013, shared with fetch.
- One sub-module, `icache_line_ram`: valid/tag/data arrays with async clear of valid, one write port, and a combinational read port.
- The FSM and hit logic stay in `icache_dm`.

## Test plan
1. After reset, `proc_read`=1, `proc_addr`=30'h0:
   - `proc_stall`=1 in the same cycle.
   - Next cycle `mem_read`=1, `mem_addr`=28'h0.
   - `mem_ready` pulses 5 cycles later with `mem_rdata`=128'h33333333_22222222_11111111_00000000.
   - The following cycle `proc_stall`=0 and `proc_rdata`=32'h00000000.
2. Then `proc_addr`=1, 2, 3 on consecutive cycles: zero stalls; `proc_rdata` = 32'h11111111, 32'h22222222, 32'h33333333; `mem_read` stays 0.
3. `proc_addr`=30'h20 (index 0, tag 1):
   - miss, fill with `mem_addr`=28'h8;
   - re-reading 30'h0 misses again, so `mem_read` reasserts with `mem_addr`=28'h0.
4. `rst_n` pulsed low during S_FETCH:
   - `mem_read` drops immediately and stays 0 while `proc_read`=0;
   - a late `mem_ready` is ignored;
   - the next read of 30'h0 misses.
5. `proc_write`=1, `proc_read`=0 for 10 cycles: `proc_stall`=0, `mem_read`=0, `mem_write`=0 throughout.
6. With `ICACHE_PERF_EN`, scenarios 1–2: `miss_cnt`=1, `hit_cnt`=4.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_dm_pkg;

    localparam int LINE_W = 128;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP = 32'h00000013;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

endpackage

// File: rtl/icache_line_ram.sv
// Valid/tag/data storage for icache_dm: one write port, one combinational read port.
module icache_line_ram
    import icache_dm_pkg::*;
#(
    parameter int LINE_NUM = 8,
    parameter int IW       = $clog2(LINE_NUM),
    parameter int TAG_W    = 28 - IW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IW-1:0]     widx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IW-1:0]     ridx,
    output logic              rvalid,
    output logic [TAG_W-1:0]  rtag,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_NUM-1:0]         valid;
    logic [TAG_W-1:0]            tag_mem  [LINE_NUM];
    logic [LINE_W-1:0]           data_mem [LINE_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (we)
            valid[widx] <= 1'b1;
    end

    // Tag and data are left unreset; valid alone gates their use.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[widx]  <= wtag;
            data_mem[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tag_mem[ridx];
    assign rdata  = data_mem[ridx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 128-bit line refill.
// Define ICACHE_PERF_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINE_NUM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [29:0]       proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [27:0]       mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int IW    = $clog2(LINE_NUM);
    localparam int TAG_W = 28 - IW;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [TAG_W-1:0]  tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              hit;
    logic              miss_req;
    logic              fill;
    logic              unused_in;

    assign idx      = proc_addr[IW+1:2];
    assign tag      = proc_addr[29:IW+2];
    assign hit      = line_valid && (line_tag == tag);
    assign miss_req = (state == S_IDLE) && proc_read && !hit;
    assign fill     = (state == S_FETCH) && mem_ready;

    // Fill targets the latched line address, not the live PC, so a redirect
    // mid-fill cannot corrupt a different line.
    icache_line_ram #(
        .LINE_NUM (LINE_NUM),
        .IW       (IW),
        .TAG_W    (TAG_W)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (fill),
        .widx   (mem_addr[IW-1:0]),
        .wtag   (mem_addr[27:IW]),
        .wdata  (mem_rdata),
        .ridx   (idx),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mem_read <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        state    <= S_FETCH;
                        mem_read <= 1'b1;
                        mem_addr <= proc_addr[29:2];
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state    <= S_IDLE;
                        mem_read <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign proc_stall = miss_req || (state == S_FETCH);
    assign proc_rdata = line_data[{proc_addr[1:0], 5'd0} +: WORD_W];
    assign mem_write  = 1'b0;
    assign mem_wdata  = '0;
    assign unused_in  = ^{proc_write, proc_wdata};

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if ((state == S_IDLE) && proc_read && hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_req && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: expected words queued on request, popped on unstalled read.
module tb_icache_dm;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
`ifdef ICACHE_PERF_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    icache_dm #(.LINE_NUM(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Memory image: word at word-address w holds w * 0x11111111.
    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++)
            l[32*k +: 32] = ({la, 2'(k)}) * 32'h11111111;
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
    endtask

    // Issue one read; on a miss act as memory, answering dly cycles after mem_read rises.
    task automatic rd(input logic [29:0] a, input bit miss, input int dly);
        int stalls;
        int nmr;
        bit done;
        stalls = 0;
        nmr    = 0;
        done   = 0;
        exp_q.push_back(a * 32'h11111111);
        proc_read = 1'b1;
        proc_addr = a;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("miss_det", 32'(proc_stall), 32'(miss));
                chk("mr_early", 32'(mem_read), 32'd0);
            end
            if (!proc_stall) begin
                chk("rdata", proc_rdata, exp_q.pop_front());
                chk("stalls", 32'(stalls), miss ? 32'(dly + 1) : 32'd0);
                chk("mr_off", 32'(mem_read), 32'd0);
                done = 1;
            end else begin
                stalls++;
                if (mem_read) begin
                    nmr++;
                    if (nmr == dly) begin
                        chk("mem_addr", 32'(mem_addr), 32'(a[29:2]));
                        mem_ready = 1'b1;
                        mem_rdata = line_of(a[29:2]);
                    end
                end
            end
            step();
        end
        if (!done) begin
            chk("timeout", 32'd1, 32'd0);
            void'(exp_q.pop_front());
        end
        proc_read = 1'b0;
    endtask

    initial begin
        step();
        @(negedge clk);
        chk("rst_mr", 32'(mem_read), 32'd0);
        chk("rst_ma", 32'(mem_addr), 32'd0);
        chk("rst_stall", 32'(proc_stall), 32'd0);
        rst_n = 1'b1;
        step();

        // Cold miss on line 0, then the other three words hit.
        rd(30'h0, 1'b1, 5);
        rd(30'h1, 1'b0, 0);
        rd(30'h2, 1'b0, 0);
        rd(30'h3, 1'b0, 0);
`ifdef ICACHE_PERF_EN
        @(negedge clk);
        chk("miss_cnt", miss_cnt, 32'd1);
        chk("hit_cnt", hit_cnt, 32'd4);
        step();
`endif

        // Conflict miss on index 0, then the evicted line misses again.
        rd(30'h20, 1'b1, 2);
        rd(30'h0, 1'b1, 1);
        rd(30'h1, 1'b0, 0);

        // mem_ready while idle must not touch the cache.
        mem_ready = 1'b1;
        mem_rdata = {4{32'hDEADBEEF}};
        step();
        rd(30'h2, 1'b0, 0);

        // Redirect mid-fill: fill completes to 0x40's line, new PC looked up after.
        proc_read = 1'b1;
        proc_addr = 30'h40;
        step();
        proc_addr = 30'h5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("redir_mr", 32'(mem_read), 32'd1);
            chk("redir_ma", 32'(mem_addr), 32'h10);
            chk("redir_stall", 32'(proc_stall), 32'd1);
            if (i == 1) begin
                mem_ready = 1'b1;
                mem_rdata = line_of(28'h10);
            end
            step();
        end
        rd(30'h5, 1'b1, 3);
        rd(30'h40, 1'b0, 0);
        rd(30'h43, 1'b0, 0);

        // Reset during fill abandons it; a late mem_ready is ignored.
        proc_read = 1'b1;
        proc_addr = 30'h8;
        step();
        step();
        proc_read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_fill_mr", 32'(mem_read), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_mr", 32'(mem_read), 32'd0);
            if (i == 1) begin
                mem_ready = 1'b1;
                mem_rdata = line_of(28'h0);
            end
            step();
        end
        rd(30'h0, 1'b1, 2);

        // Writes are ignored entirely.
        proc_write = 1'b1;
        proc_wdata = 32'hCAFEF00D;
        proc_addr  = 30'h33;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("wr_stall", 32'(proc_stall), 32'd0);
            chk("wr_mr", 32'(mem_read), 32'd0);
            chk("wr_mw", 32'(mem_write), 32'd0);
            step();
        end
        proc_write = 1'b0;
        rd(30'h1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
